// File: rtl/sys_defs.sv
// sys_defs: shared retire-stage types (tags, ROB/free-list/AMT packets, FSM states).
// No ports; XLEN defaults to 32 when not supplied on the command line.
`ifndef XLEN
`define XLEN 32
`endif
package sys_defs;
  localparam int XLEN = `XLEN;
  localparam int PRN_W = 6;
  localparam int AREG_W = 5;
  typedef struct packed {
    logic             valid;
    logic [PRN_W-1:0] prn;
  } TAG;
  typedef struct packed {
    logic              retire_en;
    TAG                retire_t;
    TAG                retire_t_old;
    logic [31:0]       inst;
    logic              halt;
    logic              wr_mem;
    logic [AREG_W-1:0] dest_reg_idx;
    logic [XLEN-1:0]   NPC;
    logic [XLEN-1:0]   result;
    logic [XLEN-1:0]   rs2_value;
    logic              take_branch;
  } ROB_IR_PACKET;
  typedef struct packed {
    logic free_en;
    TAG   free_tag;
  } IR_FL_PACKET;
  typedef struct packed {
    logic              wr_en;
    logic [AREG_W-1:0] idx;
    TAG                tag;
  } IR_AMT_PACKET;
  typedef enum logic [1:0] {IDLE, STORE, COMMIT, HALTED} retire_state_e;
endpackage

// File: rtl/retire_if.sv
// retire_if: store handshake between retire stage and data memory.
// Ports: mem_req/mem_addr/mem_wdata driven by the retire stage (master), mem_ack by memory (slave).
interface retire_if #(parameter int XLEN_P = sys_defs::XLEN);
  logic              mem_req;
  logic [XLEN_P-1:0] mem_addr;
  logic [XLEN_P-1:0] mem_wdata;
  logic              mem_ack;
  modport master (output mem_req, mem_addr, mem_wdata, input mem_ack);
  modport slave (input mem_req, mem_addr, mem_wdata, output mem_ack);
endinterface

// File: rtl/retire_store_ctrl.sv
// retire_store_ctrl: IDLE/STORE/COMMIT/HALTED sequencing of the ROB head retire.
// Ports: clock, reset_n (async active-low), head retire_en/wr_mem/halt, mem_ack in;
//        ir_stall, mem_req, retire (retire event), capture (latch store addr/data), halted out.
module retire_store_ctrl
  import sys_defs::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic retire_en_i,
  input  logic wr_mem_i,
  input  logic halt_i,
  input  logic mem_ack_i,
  output logic ir_stall_o,
  output logic mem_req_o,
  output logic retire_o,
  output logic capture_o,
  output logic halted_o
);
  retire_state_e state_q, state_d;
  logic stall;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    stall = 1'b0;
    mem_req_o = 1'b0;
    case (state_q)
      IDLE: begin
        stall = retire_en_i && wr_mem_i && !halt_i;
        state_d = stall ? STORE : (retire_en_i && halt_i) ? HALTED : IDLE;
      end
      STORE: begin
        stall = 1'b1;
        mem_req_o = 1'b1;
        state_d = mem_ack_i ? COMMIT : STORE;
      end
      COMMIT: state_d = retire_en_i ? IDLE : COMMIT;
      default: stall = 1'b1;
    endcase
  end
  // Reset must silence stall and the retire event immediately, not just at the next edge.
  assign ir_stall_o = reset_n && stall;
  assign retire_o = reset_n && retire_en_i && !stall;
  assign capture_o = (state_q == IDLE) && stall;
  assign halted_o = (state_q == HALTED);
endmodule

// File: rtl/retire.sv
// retire: in-order retire stage; frees old tags, updates the AMT, and performs stores at the ROB head.
// Ports: clock, reset_n (async active-low), rob_ir_packet (ROB head), ir_stall, mem (retire_if.master
//        store handshake), ir_fl_packet (free list), ir_amt_packet (architectural map), halted.
// Macro RETIRE_TRACE_EN adds retired_count and registered wb_valid/wb_reg_idx/wb_data/wb_NPC.
`ifndef XLEN
`define XLEN 32
`endif
module retire
  import sys_defs::*;
#(
  parameter int XLEN_P = `XLEN,
  parameter int ARCH_REGS = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  ROB_IR_PACKET rob_ir_packet,
  output logic         ir_stall,
  retire_if.master     mem,
  output IR_FL_PACKET  ir_fl_packet,
  output IR_AMT_PACKET ir_amt_packet,
  output logic         halted
`ifdef RETIRE_TRACE_EN
  ,
  output logic [63:0]       retired_count,
  output logic              wb_valid,
  output logic [AREG_W-1:0] wb_reg_idx,
  output logic [XLEN_P-1:0] wb_data,
  output logic [XLEN_P-1:0] wb_NPC
`endif
);
  logic retire_ev, capture, write_ok, free_en, amt_en, unused_bits;
  logic [XLEN_P-1:0] addr_q, addr_d, data_q, data_d;
  retire_store_ctrl u_ctrl (
    .clock       (clock),
    .reset_n     (reset_n),
    .retire_en_i (rob_ir_packet.retire_en),
    .wr_mem_i    (rob_ir_packet.wr_mem),
    .halt_i      (rob_ir_packet.halt),
    .mem_ack_i   (mem.mem_ack),
    .ir_stall_o  (ir_stall),
    .mem_req_o   (mem.mem_req),
    .retire_o    (retire_ev),
    .capture_o   (capture),
    .halted_o    (halted)
  );
  // Store address/data are latched on entry to STORE so they stay stable for the whole request.
  assign addr_d = capture ? XLEN_P'(rob_ir_packet.result) : addr_q;
  assign data_d = capture ? XLEN_P'(rob_ir_packet.rs2_value) : data_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      addr_q <= '0;
      data_q <= '0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
    end
  assign mem.mem_addr = addr_q;
  assign mem.mem_wdata = data_q;
  // A halting instruction retires but commits no register state.
  assign write_ok = retire_ev && !rob_ir_packet.halt;
  assign free_en = write_ok && rob_ir_packet.retire_t_old.valid;
  assign amt_en = write_ok && rob_ir_packet.retire_t.valid && rob_ir_packet.dest_reg_idx != '0
                  && 32'(rob_ir_packet.dest_reg_idx) < ARCH_REGS;
  assign ir_fl_packet = '{free_en: free_en, free_tag: free_en ? rob_ir_packet.retire_t_old : TAG'('0)};
  assign ir_amt_packet = '{wr_en: amt_en,
                           idx: amt_en ? rob_ir_packet.dest_reg_idx : '0,
                           tag: amt_en ? rob_ir_packet.retire_t : TAG'('0)};
  assign unused_bits = ^{rob_ir_packet.inst, rob_ir_packet.take_branch, rob_ir_packet.NPC};
`ifdef RETIRE_TRACE_EN
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      retired_count <= '0;
      wb_valid <= 1'b0;
      wb_reg_idx <= '0;
      wb_data <= '0;
      wb_NPC <= '0;
    end else begin
      retired_count <= retired_count + 64'(retire_ev);
      wb_valid <= retire_ev;
      if (retire_ev) begin
        wb_reg_idx <= rob_ir_packet.dest_reg_idx;
        wb_data <= XLEN_P'(rob_ir_packet.result);
        wb_NPC <= XLEN_P'(rob_ir_packet.NPC);
      end
    end
`endif
endmodule

// File: tb/tb_retire.sv
// tb_retire: directed self-checking bench for the retire stage.
module tb_retire;
  import sys_defs::*;
  logic clock = 1'b0;
  logic reset_n;
  logic ir_stall, halted;
  ROB_IR_PACKET rob;
  IR_FL_PACKET fl;
  IR_AMT_PACKET amt;
  int checks = 0;
  int failures = 0;
  retire_if mem_if ();
`ifdef RETIRE_TRACE_EN
  logic [63:0] retired_count;
  logic wb_valid;
  logic [AREG_W-1:0] wb_reg_idx;
  logic [XLEN-1:0] wb_data, wb_NPC;
`endif
  retire dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rob_ir_packet (rob),
    .ir_stall      (ir_stall),
    .mem           (mem_if),
    .ir_fl_packet  (fl),
    .ir_amt_packet (amt),
    .halted        (halted)
`ifdef RETIRE_TRACE_EN
    ,
    .retired_count (retired_count),
    .wb_valid      (wb_valid),
    .wb_reg_idx    (wb_reg_idx),
    .wb_data       (wb_data),
    .wb_NPC        (wb_NPC)
`endif
  );
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    rob = '0;
    mem_if.mem_ack = 1'b0;
    reset_n = 1'b0;
    #3;
    chk("rst_halted", 64'(halted), 0);
    chk("rst_req", 64'(mem_if.mem_req), 0);
    chk("rst_stall", 64'(ir_stall), 0);
    chk("rst_free", 64'(fl.free_en), 0);
    chk("rst_amt", 64'(amt.wr_en), 0);
    tick;
    tick;
    reset_n = 1'b1;
    rob.retire_en = 1'b1;
    rob.retire_t = '{valid: 1'b1, prn: 6'd40};
    rob.retire_t_old = '{valid: 1'b1, prn: 6'd7};
    rob.dest_reg_idx = 5'd5;
    #1;
    chk("alu_stall", 64'(ir_stall), 0);
    chk("alu_free_en", 64'(fl.free_en), 1);
    chk("alu_free_tag", 64'(fl.free_tag.prn), 7);
    chk("alu_amt_en", 64'(amt.wr_en), 1);
    chk("alu_amt_idx", 64'(amt.idx), 5);
    chk("alu_amt_tag", 64'(amt.tag.prn), 40);
    tick;
    rob.retire_t_old.valid = 1'b0;
    rob.dest_reg_idx = 5'd0;
    #1;
    chk("x0_amt_en", 64'(amt.wr_en), 0);
    chk("x0_free_en", 64'(fl.free_en), 0);
    chk("x0_stall", 64'(ir_stall), 0);
    tick;
    rob.dest_reg_idx = 5'd3;
    #1;
    chk("x3_amt_en", 64'(amt.wr_en), 1);
    chk("x3_free_en", 64'(fl.free_en), 0);
    tick;
    rob.retire_en = 1'b0;
    rob.retire_t_old.valid = 1'b1;
    #1;
    chk("noret_stall", 64'(ir_stall), 0);
    chk("noret_free", 64'(fl.free_en), 0);
    chk("noret_amt", 64'(amt.wr_en), 0);
    tick;
    rob.retire_en = 1'b1;
    rob.wr_mem = 1'b1;
    rob.result = 32'h100;
    rob.rs2_value = 32'hDEAD;
    rob.retire_t = '{valid: 1'b1, prn: 6'd12};
    rob.retire_t_old = '{valid: 1'b1, prn: 6'd9};
    rob.dest_reg_idx = 5'd6;
    #1;
    chk("st_idle_stall", 64'(ir_stall), 1);
    chk("st_idle_req", 64'(mem_if.mem_req), 0);
    chk("st_idle_free", 64'(fl.free_en), 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("st_req", 64'(mem_if.mem_req), 1);
      chk("st_addr", 64'(mem_if.mem_addr), 64'h100);
      chk("st_data", 64'(mem_if.mem_wdata), 64'hDEAD);
      chk("st_stall", 64'(ir_stall), 1);
      chk("st_amt", 64'(amt.wr_en), 0);
      if (i == 3) mem_if.mem_ack = 1'b1;
    end
    tick;
    mem_if.mem_ack = 1'b0;
    #1;
    chk("cm_stall", 64'(ir_stall), 0);
    chk("cm_req", 64'(mem_if.mem_req), 0);
    chk("cm_free_en", 64'(fl.free_en), 1);
    chk("cm_free_tag", 64'(fl.free_tag.prn), 9);
    chk("cm_amt_en", 64'(amt.wr_en), 1);
    chk("cm_amt_idx", 64'(amt.idx), 6);
    chk("cm_amt_tag", 64'(amt.tag.prn), 12);
    tick;
    rob.retire_en = 1'b0;
    #1;
    chk("post_cm_req", 64'(mem_if.mem_req), 0);
    chk("post_cm_stall", 64'(ir_stall), 0);
    rob.retire_en = 1'b1;
    tick;
    chk("rs_store_req", 64'(mem_if.mem_req), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rs_async_req", 64'(mem_if.mem_req), 0);
    chk("rs_async_stall", 64'(ir_stall), 0);
    chk("rs_async_free", 64'(fl.free_en), 0);
    chk("rs_async_amt", 64'(amt.wr_en), 0);
    rob.retire_en = 1'b0;
    rob.wr_mem = 1'b0;
    tick;
    reset_n = 1'b1;
    mem_if.mem_ack = 1'b1;
    tick;
    mem_if.mem_ack = 1'b0;
    rob.retire_en = 1'b1;
    rob.wr_mem = 1'b1;
    #1;
    chk("stray_ack_stall", 64'(ir_stall), 1);
    chk("stray_ack_req", 64'(mem_if.mem_req), 0);
    rob.retire_en = 1'b0;
    rob.wr_mem = 1'b0;
`ifdef RETIRE_TRACE_EN
    chk("tr_count0", retired_count, 0);
    rob.retire_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rob.dest_reg_idx = 5'(i + 1);
      rob.result = 32'(i * 3);
      tick;
      chk("tr_wb_valid", 64'(wb_valid), 1);
      chk("tr_wb_idx", 64'(wb_reg_idx), 64'(i + 1));
      chk("tr_wb_data", 64'(wb_data), 64'(i * 3));
    end
    rob.retire_en = 1'b0;
    chk("tr_count10", retired_count, 10);
    tick;
    chk("tr_wb_idle", 64'(wb_valid), 0);
`endif
    tick;
    rob.retire_en = 1'b1;
    rob.halt = 1'b1;
    rob.retire_t = '{valid: 1'b1, prn: 6'd20};
    rob.retire_t_old = '{valid: 1'b1, prn: 6'd21};
    rob.dest_reg_idx = 5'd4;
    #1;
    chk("halt_stall", 64'(ir_stall), 0);
    chk("halt_free", 64'(fl.free_en), 0);
    chk("halt_amt", 64'(amt.wr_en), 0);
    chk("halt_not_yet", 64'(halted), 0);
    tick;
    rob.halt = 1'b0;
    #1;
    chk("halted_flag", 64'(halted), 1);
    chk("halted_stall", 64'(ir_stall), 1);
    chk("halted_free", 64'(fl.free_en), 0);
    chk("halted_amt", 64'(amt.wr_en), 0);
    chk("halted_req", 64'(mem_if.mem_req), 0);
    tick;
    tick;
    chk("halted_stays", 64'(halted), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/retire.md
RETIRE -- requirements
Module: retire

Interface
REQ-001 SHALL have parameter XLEN_P, default `XLEN, data/address width.
REQ-002 SHALL have parameter ARCH_REGS, default 32, architectural register count (idx width 5).
REQ-003 SHALL have port clock  input  1  single clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rob_ir_packet  input  ROB_IR_PACKET  ROB head: retire_en, retire_t, retire_t_old, inst, halt, wr_mem, dest_reg_idx, NPC, result, rs2_value, take_branch.
REQ-006 SHALL have port ir_stall  output  1  combinational; ROB advances head only when retire_en && !ir_stall.
REQ-007 SHALL have port mem_req / mem_addr / mem_wdata  output  1/XLEN/XLEN  store request, address = result, data = rs2_value.
REQ-008 SHALL have port mem_ack  input  1  memory accepted store.
REQ-009 SHALL have port ir_fl_packet  output  IR_FL_PACKET  free_en, free_tag: returns t_old to free list.
REQ-010 SHALL have port ir_amt_packet  output  IR_AMT_PACKET  wr_en, idx, tag: architectural map update.
REQ-011 SHALL have port halted  output  1  registered; program halted.

Function
REQ-012 SHALL implement FSM states IDLE, STORE, COMMIT, HALTED.
REQ-013 Retire event: cycle where retire_en && !ir_stall; at most one per cycle.
REQ-014 IDLE, head valid, !wr_mem: ir_stall=0; instruction retires same cycle (zero added latency).
REQ-015 IDLE, head valid, wr_mem: ir_stall=1; next state STORE.
REQ-016 STORE: mem_req=1, address/data held stable until mem_ack; ir_stall=1; on mem_ack next state COMMIT.
REQ-017 COMMIT: ir_stall=0, store retires, mem_req=0, next state IDLE; minimum store retire latency 3 cycles with same-cycle ack.
REQ-018 On retire event: free_en=1 and free_tag=retire_t_old iff retire_t_old.valid; amt wr_en=1, idx=dest_reg_idx, tag=retire_t iff retire_t.valid && dest_reg_idx!=0.
REQ-019 Retire of halt instruction: no free/AMT write; next state HALTED; halted=1 from next cycle.
REQ-020 HALTED: ir_stall=1, mem_req=0, all write enables 0; left only by reset.
REQ-021 retire_en=0: ir_stall=0, no writes, state unchanged.
REQ-022 free/AMT outputs combinational from head, valid only in retire-event cycle.

Reset
REQ-023 reset_n low: state IDLE, halted=0, mem_req=0, ir_stall=0, all enables 0, trace outputs 0, immediately (asynchronous).
REQ-024 Reset during STORE: request dropped; pending ack after release ignored in IDLE.

Configuration
REQ-025 RETIRE_TRACE_EN defined: ports retired_count (64-bit, increments per retire event, wraps) and wb_valid/wb_reg_idx/wb_data/wb_NPC, registered one cycle after retire event; absent when undefined, core behaviour identical.

Structure
REQ-026 ROB_IR_PACKET, IR_FL_PACKET, IR_AMT_PACKET, TAG and FSM state enum SHALL live in the shared sys_defs package.
REQ-027 Store handshake FSM SHALL be one sub-module, retire_store_ctrl; retire SHALL instantiate it once.

Verification
REQ-028 ALU retire, t=P40 valid, t_old=P7 valid, dest=x5 -> same cycle free_tag=P7, AMT x5<-P40, ir_stall=0.
REQ-029 dest=x0, t_old invalid -> no AMT write, no free, retire proceeds.
REQ-030 Store result=0x100, rs2_value=0xDEAD, ack after 4 cycles -> mem_req held 4 cycles with stable addr/data, ir_stall high until COMMIT, retire in COMMIT.
REQ-031 Halt at head -> halted=1 next cycle; later ALU head -> ir_stall=1, no writes.
REQ-032 Reset_n low mid-STORE -> mem_req=0 asynchronously, state IDLE; stray ack ignored.
REQ-033 RETIRE_TRACE_EN, 10 back-to-back ALU retires -> retired_count=10, wb_valid each cycle lagging by one.
